// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM-stage data-memory access unit for an RV32IM pipeline.
//                Converts decoded load/store controls into a single word-wide
//                request/acknowledge transaction with byte-lane enables and
//                load sign/zero extension, stalling the pipeline meanwhile.
//                Optional macro MEM_ACCESS_TIMEOUT_EN adds an ACCESS timeout
//                of TIMEOUT_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  MEM_READ,
  input  logic [2:0]  MEM_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY_WAIT,
  output logic        ACCESS_FAULT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [29:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Request decode
  logic        w_is_load;
  logic        w_is_store;
  logic [2:0]  w_ld_f3;
  logic [1:0]  w_st_f3;
  logic        w_illegal;
  logic        w_half;
  logic        w_word;
  logic        w_misaligned;
  logic        w_fault_req;
  logic        w_start;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // Latched transaction context
  logic [2:0]  r_ld_f3;
  logic [1:0]  r_off;

  // Load extraction
  logic [7:0]  w_byte;
  logic [15:0] w_halfword;
  logic [31:0] w_load_result;

  logic        w_timeout;
  logic        w_timeout_fault;

  // Range guard for the timeout parameter: the counter is 8 bits wide, so
  // values outside 1..255 are not meaningful. The block is intentionally
  // empty; it only ties the parameter into elaboration in every build.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_bad
  end

  assign w_is_load  = MEM_READ[3];
  assign w_is_store = MEM_WRITE[2];
  assign w_ld_f3    = MEM_READ[2:0];
  assign w_st_f3    = MEM_WRITE[1:0];

  // Illegal: both valids, reserved load funct3 (011/110/111), store funct3 11
  assign w_illegal = (w_is_load & w_is_store)
                   | (w_is_load & ((w_ld_f3 == 3'b011) | (w_ld_f3[2:1] == 2'b11)))
                   | (w_is_store & (w_st_f3 == 2'b11));

  assign w_half = (w_is_load & (w_ld_f3[1:0] == 2'b01)) | (w_is_store & (w_st_f3 == 2'b01));
  assign w_word = (w_is_load & (w_ld_f3 == 3'b010))     | (w_is_store & (w_st_f3 == 2'b10));

  assign w_misaligned = (w_half & ADDRESS[0]) | (w_word & (|ADDRESS[1:0]));
  assign w_fault_req  = (w_is_load | w_is_store) & (w_illegal | w_misaligned);
  assign w_start      = (w_is_load ^ w_is_store) & ~w_illegal & ~w_misaligned;

  // Store lane replication and byte enables; loads always read the full word
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (w_is_store) begin
      case (w_st_f3)
        2'b00: begin
          w_wdata = {4{WRITE_DATA[7:0]}};
          w_be    = 4'b0001 << ADDRESS[1:0];
        end
        2'b01: begin
          w_wdata = {2{WRITE_DATA[15:0]}};
          w_be    = ADDRESS[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_wdata = WRITE_DATA;
          w_be    = 4'b1111;
        end
      endcase
    end
  end

  // Select and extend the addressed byte/halfword of the returned word
  always_comb begin
    w_byte     = MEM_RDATA[{r_off, 3'b000} +: 8];
    w_halfword = MEM_RDATA[{r_off[1], 4'b0000} +: 16];
    case (r_ld_f3)
      3'b000:  w_load_result = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_result = {{16{w_halfword[15]}}, w_halfword};
      3'b100:  w_load_result = {24'h0, w_byte};
      3'b101:  w_load_result = {16'h0, w_halfword};
      default: w_load_result = MEM_RDATA;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       r_timeout_fault;

  // An acknowledge in the same cycle takes priority over the timeout
  assign w_timeout       = (r_state == ST_ACCESS) && !MEM_ACK && (r_cnt == c_TIMEOUT_LAST);
  assign w_timeout_fault = r_timeout_fault;

  // ACCESS cycle counter (zero outside ACCESS) and one-shot timeout flag for DONE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt           <= 8'h0;
      r_timeout_fault <= 1'b0;
    end else begin
      r_cnt           <= (r_state == ST_ACCESS) ? r_cnt + 8'h1 : 8'h0;
      r_timeout_fault <= w_timeout;
    end
  end
`else
  assign w_timeout       = 1'b0;
  assign w_timeout_fault = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic plus the two combinational handshake outputs
  always_comb begin
    w_next_state = r_state;
    BUSY_WAIT    = 1'b0;
    ACCESS_FAULT = 1'b0;
    case (r_state)
      ST_IDLE: begin
        BUSY_WAIT    = w_start;
        ACCESS_FAULT = w_fault_req;
        if (w_start) w_next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        BUSY_WAIT = 1'b1;
        if (MEM_ACK || w_timeout) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        ACCESS_FAULT = w_timeout_fault;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (RESET) begin
      BUSY_WAIT    = 1'b0;
      ACCESS_FAULT = 1'b0;
    end
  end

  // Memory-port registers and load result capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      READ_DATA <= 32'h0;
      MEM_REQ   <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= 30'h0;
      MEM_WDATA <= 32'h0;
      MEM_BE    <= 4'h0;
      r_ld_f3   <= 3'b0;
      r_off     <= 2'b0;
    end else begin
      if (r_state == ST_IDLE && w_start) begin
        MEM_REQ   <= 1'b1;
        MEM_WE    <= w_is_store;
        MEM_ADDR  <= ADDRESS[31:2];
        MEM_BE    <= w_be;
        MEM_WDATA <= w_wdata;
        r_ld_f3   <= w_ld_f3;
        r_off     <= ADDRESS[1:0];
      end else if (r_state == ST_ACCESS) begin
        if (MEM_ACK) begin
          MEM_REQ <= 1'b0;
          if (!MEM_WE) READ_DATA <= w_load_result;
        end else if (w_timeout) begin
          MEM_REQ <= 1'b0;
          if (!MEM_WE) READ_DATA <= 32'h0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Scoreboard bench for mem_access_unit. Stimulus pushes the
//                expected memory request and completion response; a monitor
//                compares them when MEM_REQ rises and when it completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;
  logic        ACCESS_FAULT;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [29:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .ADDRESS      (ADDRESS),
    .WRITE_DATA   (WRITE_DATA),
    .READ_DATA    (READ_DATA),
    .BUSY_WAIT    (BUSY_WAIT),
    .ACCESS_FAULT (ACCESS_FAULT),
    .MEM_REQ      (MEM_REQ),
    .MEM_WE       (MEM_WE),
    .MEM_ADDR     (MEM_ADDR),
    .MEM_WDATA    (MEM_WDATA),
    .MEM_BE       (MEM_BE),
    .MEM_RDATA    (MEM_RDATA),
    .MEM_ACK      (MEM_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: request fields when MEM_REQ rises, response when it completes
  logic prev_req = 1'b0;
  always @(posedge CLK) begin
    #1;
    if (MEM_REQ && !prev_req) begin
      if (req_q.size() == 0) begin
        check("unexpected_req", 32'd1, 32'd0);
      end else begin
        req_t r;
        r = req_q.pop_front();
        check("mem_addr", {2'b0, MEM_ADDR}, {2'b0, r.addr});
        check("mem_we", {31'b0, MEM_WE}, {31'b0, r.we});
        check("mem_be", {28'b0, MEM_BE}, {28'b0, r.be});
        if (r.chk_wdata) check("mem_wdata", MEM_WDATA, r.wdata);
      end
    end else if (!MEM_REQ && prev_req && !RESET) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        resp_t s;
        s = resp_q.pop_front();
        check("read_data", READ_DATA, s.rdata);
        check("done_fault", {31'b0, ACCESS_FAULT}, {31'b0, s.fault});
        check("done_busy", {31'b0, BUSY_WAIT}, 32'd0);
      end
    end
    prev_req <= MEM_REQ;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    MEM_READ   = 4'b0;
    MEM_WRITE  = 3'b0;
    ADDRESS    = 32'h0;
    WRITE_DATA = 32'h0;
  endtask

  // Issue one legal access from IDLE (caller sits at a negedge). ack_lat = 0
  // means the memory never acknowledges.
  task automatic run_access(input logic [3:0] mr, input logic [2:0] mw,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int ack_lat,
                            input logic [29:0] exp_addr, input logic exp_we,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic chk_wdata, input logic [31:0] exp_rd,
                            input logic exp_fault, input int exp_stall);
    int   stall;
    logic done;
    MEM_READ   = mr;
    MEM_WRITE  = mw;
    ADDRESS    = addr;
    WRITE_DATA = wd;
    req_q.push_back('{addr: exp_addr, we: exp_we, be: exp_be, wdata: exp_wdata, chk_wdata: chk_wdata});
    resp_q.push_back('{rdata: exp_rd, fault: exp_fault});
    #1;
    check("start_busy", {31'b0, BUSY_WAIT}, 32'd1);
    check("start_fault", {31'b0, ACCESS_FAULT}, 32'd0);
    stall = 1;
    done  = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge CLK);
      MEM_ACK   = 1'b0;
      MEM_RDATA = ~rd;
      if (!BUSY_WAIT) begin
        done = 1'b1;
      end else begin
        stall++;
        if (ack_lat != 0 && i + 1 == ack_lat) begin
          MEM_ACK   = 1'b1;
          MEM_RDATA = rd;
        end
      end
    end
    if (!done) check("access_completes", 32'd0, 32'd1);
    check("stall_cycles", stall, exp_stall);
    clear_inputs();
    @(negedge CLK);
  endtask

  // Present a request that must be rejected in IDLE
  task automatic run_fault(input string name, input logic [3:0] mr,
                           input logic [2:0] mw, input logic [31:0] addr);
    MEM_READ   = mr;
    MEM_WRITE  = mw;
    ADDRESS    = addr;
    WRITE_DATA = 32'h5A5A5A5A;
    #1;
    check({name, "_fault"}, {31'b0, ACCESS_FAULT}, 32'd1);
    check({name, "_busy"}, {31'b0, BUSY_WAIT}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check({name, "_noreq"}, {31'b0, MEM_REQ}, 32'd0);
    end
    clear_inputs();
    @(negedge CLK);
  endtask

  initial begin
    RESET     = 1'b1;
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h0;
    clear_inputs();
    MEM_READ  = 4'b1010;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_read_data", READ_DATA, 32'h0);
    check("rst_req", {31'b0, MEM_REQ}, 32'd0);
    check("rst_addr", {2'b0, MEM_ADDR}, 32'h0);
    check("rst_be", {28'b0, MEM_BE}, 32'h0);
    check("rst_busy", {31'b0, BUSY_WAIT}, 32'd0);
    clear_inputs();
    RESET = 1'b0;
    @(negedge CLK);

    // mr/mw, addr, wdata, rdata, ack_lat, exp addr/we/be/wdata/chk, exp rd, fault, stall
    run_access(4'b1010, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 1,
               30'h40, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 2);
    run_access(4'b1000, 3'b000, 32'h103, 32'h0, 32'h80112233, 1,
               30'h40, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 2);
    run_access(4'b1100, 3'b000, 32'h103, 32'h0, 32'h80112233, 1,
               30'h40, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h00000080, 1'b0, 2);
    run_access(4'b0000, 3'b101, 32'h202, 32'h1234ABCD, 32'hFFFF0000, 2,
               30'h80, 1'b1, 4'b1100, 32'hABCDABCD, 1'b1, 32'h00000080, 1'b0, 3);
    run_access(4'b0000, 3'b100, 32'h001, 32'hAABBCC55, 32'h11111111, 1,
               30'h0, 1'b1, 4'b0010, 32'h55555555, 1'b1, 32'h00000080, 1'b0, 2);
    run_access(4'b1001, 3'b000, 32'h102, 32'h0, 32'h80011234, 3,
               30'h40, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hFFFF8001, 1'b0, 4);
    run_access(4'b1101, 3'b000, 32'h000, 32'h0, 32'h8001F234, 1,
               30'h0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0000F234, 1'b0, 2);
    run_access(4'b0000, 3'b110, 32'h300, 32'hCAFEF00D, 32'h0, 1,
               30'hC0, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h0000F234, 1'b0, 2);

    run_fault("sw_misaligned", 4'b0000, 3'b110, 32'h101);
    run_fault("ld_f3_011", 4'b1011, 3'b000, 32'h100);
    run_fault("lh_misaligned", 4'b1001, 3'b000, 32'h001);
    run_fault("ld_and_st", 4'b1010, 3'b110, 32'h000);
    run_fault("st_f3_11", 4'b0000, 3'b111, 32'h000);

    // Reset in the third ACCESS cycle of a slow load
    MEM_READ = 4'b1010;
    ADDRESS  = 32'h10;
    req_q.push_back('{addr: 30'h4, we: 1'b0, be: 4'b1111, wdata: 32'h0, chk_wdata: 1'b0});
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("pre_rst_req", {31'b0, MEM_REQ}, 32'd1);
    RESET = 1'b1;
    #1;
    check("arst_req", {31'b0, MEM_REQ}, 32'd0);
    check("arst_read_data", READ_DATA, 32'h0);
    check("arst_addr", {2'b0, MEM_ADDR}, 32'h0);
    check("arst_we_be", {27'b0, MEM_WE, MEM_BE}, 32'h0);
    check("arst_wdata", MEM_WDATA, 32'h0);
    check("arst_busy", {31'b0, BUSY_WAIT}, 32'd0);
    check("arst_fault", {31'b0, ACCESS_FAULT}, 32'd0);
    clear_inputs();
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("post_rst_req", {31'b0, MEM_REQ}, 32'd0);
    @(negedge CLK);

    run_access(4'b1010, 3'b000, 32'h008, 32'h0, 32'h13579BDF, 1,
               30'h2, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h13579BDF, 1'b0, 2);

`ifdef MEM_ACCESS_TIMEOUT_EN
    run_access(4'b1001, 3'b000, 32'h002, 32'h0, 32'h12345678, 0,
               30'h0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h0, 1'b1, 5);
`endif

    repeat (3) @(negedge CLK);
    check("req_q_empty", req_q.size(), 32'd0);
    check("resp_q_empty", resp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
